// File: rtl/parque_pkg.sv
// Shared definitions for the parking barrier controllers: FSM encoding,
// the invalid plate code and default counter sizing.
package parque_pkg;

    typedef enum logic [1:0] {
        FECHADA = 2'd0,
        ABERTA  = 2'd1,
        FECHAR  = 2'd2
    } estado_t;

    localparam logic [23:0] MATR_INVALIDA = 24'h000000;
    localparam int          CNT_W_DEF     = 7;
    localparam int          TIMEOUT_DEF   = 127;

endpackage

// File: rtl/contador_ciclos.sv
// Saturating cycle counter with synchronous clear; shared by both barrier sides.
module contador_ciclos #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Clear wins over enable so a fresh event always starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != MAX_C)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/abrir_barreira_2.sv
// Opening-side controller for barrier 2: accepts a plate, opens, waits for the
// passage sensor plus minimum open time (or timeout), then closes.
module abrir_barreira_2
    import parque_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      Matricula,
    input  logic             MatrVal,
    input  logic             sensor_passagem,
    input  logic [CNT_W-1:0] ciclos_aberto,
    output logic             Barreira2,
    output logic [CNT_W-1:0] conta_ciclos,
    output logic             MatrAceite,
    output logic             MatrErro,
    output logic [23:0]      Matr_atual
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    estado_t          state_q;
    logic             barreira_q;
    logic             aceite_q;
    logic             erro_q;
    logic [23:0]      matr_q;
    logic             passou_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] minimo;
    logic             aceita;
    logic             fecha;

    assign aceita = (state_q == FECHADA) && MatrVal && (Matricula != MATR_INVALIDA);
    assign minimo = (ciclos_aberto == '0) ? CNT_W'(1) : ciclos_aberto;
    // A sensor hit in the deciding cycle counts as well as the remembered one.
    assign fecha  = ((passou_q || sensor_passagem) && (count >= minimo)) ||
                    (count == TIMEOUT_C);

    contador_ciclos #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_contador (
        .clk  (clk),
        .reset(reset),
        .clr  (aceita),
        .en   (state_q == ABERTA),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FECHADA;
            barreira_q <= 1'b1;
            aceite_q   <= 1'b0;
            erro_q     <= 1'b0;
            matr_q     <= '0;
            passou_q   <= 1'b0;
        end else begin
            aceite_q <= 1'b0;
            erro_q   <= 1'b0;
            case (state_q)
                FECHADA: begin
                    if (aceita) begin
                        matr_q     <= Matricula;
                        passou_q   <= 1'b0;
                        aceite_q   <= 1'b1;
                        barreira_q <= 1'b0;
                        state_q    <= ABERTA;
                    end else if (MatrVal) begin
                        erro_q <= 1'b1;
                    end
                end
                ABERTA: begin
                    if (MatrVal) erro_q <= 1'b1;
                    if (sensor_passagem) passou_q <= 1'b1;
                    if (fecha) state_q <= FECHAR;
                end
                FECHAR: begin
                    if (MatrVal) erro_q <= 1'b1;
                    barreira_q <= 1'b1;
                    state_q    <= FECHADA;
                end
                default: begin
                    barreira_q <= 1'b1;
                    state_q    <= FECHADA;
                end
            endcase
        end
    end

    assign Barreira2    = barreira_q;
    assign conta_ciclos = count;
    assign MatrAceite   = aceite_q;
    assign MatrErro     = erro_q;
    assign Matr_atual   = matr_q;

endmodule

// File: tb/tb_abrir_barreira_2.sv
// Scoreboard bench for abrir_barreira_2: stimulus pushes expected events,
// a negedge monitor pops them when the DUT pulses or closes the barrier.
module tb_abrir_barreira_2;

    localparam int K_ACE = 1;
    localparam int K_ERR = 2;
    localparam int K_FEC = 3;

    typedef struct {
        int          kind;
        logic [23:0] matr;
        logic [6:0]  conta;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] Matricula = '0;
    logic        MatrVal = 1'b0;
    logic        sensor_passagem = 1'b0;
    logic [6:0]  ciclos_aberto = 7'd10;
    logic        Barreira2;
    logic [6:0]  conta_ciclos;
    logic        MatrAceite;
    logic        MatrErro;
    logic [23:0] Matr_atual;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass = 0;
    bit  ign_close = 1'b1;
    bit  bar_prev = 1'b1;

    abrir_barreira_2 dut (
        .clk            (clk),
        .reset          (reset),
        .Matricula      (Matricula),
        .MatrVal        (MatrVal),
        .sensor_passagem(sensor_passagem),
        .ciclos_aberto  (ciclos_aberto),
        .Barreira2      (Barreira2),
        .conta_ciclos   (conta_ciclos),
        .MatrAceite     (MatrAceite),
        .MatrErro       (MatrErro),
        .Matr_atual     (Matr_atual)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", nm, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] m, input logic [6:0] c);
        ev_t e;
        e.kind = kind;
        e.matr = m;
        e.conta = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event_kind", kind, 0);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_matr", Matr_atual, e.matr);
            chk("event_conta", conta_ciclos, e.conta);
            if (kind == K_ACE) chk("event_open", Barreira2, 1'b0);
        end
    endtask

    // Monitor: one transaction per output event.
    always @(negedge clk) begin
        if (MatrAceite) pop_check(K_ACE);
        if (MatrErro) pop_check(K_ERR);
        if (Barreira2 && !bar_prev && !ign_close) pop_check(K_FEC);
        bar_prev = Barreira2;
    end

    // Presents a plate at the current negedge for exactly one cycle.
    task automatic plate(input logic [23:0] m);
        Matricula = m;
        MatrVal = 1'b1;
        @(negedge clk);
        MatrVal = 1'b0;
        Matricula = '0;
    endtask

    task automatic sensor_pulse();
        sensor_passagem = 1'b1;
        @(negedge clk);
        sensor_passagem = 1'b0;
    endtask

    task automatic wait_conta(input logic [6:0] v);
        int k = 0;
        while (conta_ciclos !== v && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("wait_conta_timeout", conta_ciclos, v);
    endtask

    task automatic wait_closed();
        int k = 0;
        while (Barreira2 !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("wait_closed_timeout", Barreira2, 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_barreira", Barreira2, 1'b1);
        chk("rst_conta", conta_ciclos, 7'd0);
        chk("rst_matr", Matr_atual, 24'h0);
        chk("rst_pulses", {MatrAceite, MatrErro}, 2'b00);
        @(negedge clk);
        ign_close = 1'b0;

        // Normal pass: sensor at count 15, close decided there, held at 16.
        ciclos_aberto = 7'd10;
        push(K_ACE, 24'h4A21BC, 7'd0);
        push(K_FEC, 24'h4A21BC, 7'd16);
        plate(24'h4A21BC);
        wait_conta(7'd15);
        sensor_pulse();
        chk("normal_open_after_decision", Barreira2, 1'b0);
        @(negedge clk);
        chk("normal_closed_two_edges", Barreira2, 1'b1);
        @(negedge clk);
        chk("normal_conta_held", conta_ciclos, 7'd16);

        // Zero plate while closed is rejected.
        push(K_ERR, 24'h4A21BC, 7'd16);
        plate(24'h000000);
        @(negedge clk);
        chk("zero_plate_stays_closed", Barreira2, 1'b1);

        // Early sensor remembered; repeat plate during ABERTA rejected.
        ciclos_aberto = 7'd20;
        push(K_ACE, 24'h00ABCD, 7'd0);
        plate(24'h00ABCD);
        wait_conta(7'd3);
        sensor_pulse();
        wait_conta(7'd5);
        push(K_ERR, 24'h00ABCD, 7'd6);
        push(K_FEC, 24'h00ABCD, 7'd21);
        plate(24'h111111);
        wait_conta(7'd19);
        chk("early_still_open", Barreira2, 1'b0);
        wait_closed();

        // Timeout without any passage.
        ciclos_aberto = 7'd10;
        push(K_ACE, 24'h777777, 7'd0);
        push(K_FEC, 24'h777777, 7'd127);
        plate(24'h777777);
        wait_closed();

        // ciclos_aberto = 0 behaves as 1.
        ciclos_aberto = 7'd0;
        push(K_ACE, 24'h0A0A0A, 7'd0);
        push(K_FEC, 24'h0A0A0A, 7'd2);
        plate(24'h0A0A0A);
        sensor_pulse();
        wait_closed();

        // Reset in the middle of an open event.
        ciclos_aberto = 7'd10;
        push(K_ACE, 24'h123456, 7'd0);
        plate(24'h123456);
        wait_conta(7'd5);
        ign_close = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_barreira", Barreira2, 1'b1);
        chk("midrst_conta", conta_ciclos, 7'd0);
        chk("midrst_matr", Matr_atual, 24'h0);
        @(negedge clk);
        ign_close = 1'b0;

        // Normal reopening after reset, early sensor with minimum 2.
        ciclos_aberto = 7'd2;
        push(K_ACE, 24'h654321, 7'd0);
        push(K_FEC, 24'h654321, 7'd3);
        plate(24'h654321);
        wait_conta(7'd1);
        sensor_pulse();
        wait_closed();

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/abrir_barreira_2.md
# abrir_barreira_2

Opening-side controller for parking barrier 2, the counterpart to the barrier-closing logic. On a valid licence-plate strobe (`Matricula`/`MatrVal`) it opens the barrier, counts open cycles on `conta_ciclos`, waits for the car-passage sensor and the minimum open time, then closes the barrier. The `conta_ciclos` output is the cycle count that the closing logic compares against `ciclos_fechado`. A closed barrier is `Barreira2 = 1`, the same polarity the closing logic drives.

## Interface
Parameters:
- `CNT_W`, default 7: width of the cycle counter and of `ciclos_aberto`.
- `TIMEOUT`, default 127: count at which the barrier closes unconditionally, even if no passage was seen.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `Matricula`, in, 24: licence plate code. Valid only while `MatrVal = 1`.
- `MatrVal`, in, 1: one-cycle plate-valid strobe.
- `sensor_passagem`, in, 1: car-passage sensor, already synchronised, active-high.
- `ciclos_aberto`, in, CNT_W: minimum number of open cycles. A value of 0 is treated as 1.
- `Barreira2`, out, 1: barrier state. 1 = closed, 0 = open.
- `conta_ciclos`, out, CNT_W: cycles elapsed since the barrier opened.
- `MatrAceite`, out, 1: one-cycle pulse when a plate is accepted.
- `MatrErro`, out, 1: one-cycle pulse when a plate is rejected or ignored.
- `Matr_atual`, out, 24: latched plate of the current open event.

## Operation
- The state machine has three states: FECHADA, ABERTA, FECHAR.
- **FECHADA**
  - If `MatrVal = 1` and `Matricula != 0`:
    - latch `Matr_atual`;
    - clear `conta_ciclos` to 0;
    - clear the passage flag;
    - pulse `MatrAceite`;
    - go to ABERTA.
  - If `MatrVal = 1` and `Matricula = 0`: pulse `MatrErro` and stay in FECHADA.
- **ABERTA**
  - `Barreira2 = 0`.
  - `conta_ciclos` increments by 1 every cycle and saturates at `TIMEOUT`.
  - A sticky flag `passou` is set when `sensor_passagem = 1`.
  - Go to FECHAR when either condition holds:
    - `passou` (including a sensor hit this cycle) is set and `conta_ciclos >= max(ciclos_aberto, 1)`;
    - `conta_ciclos = TIMEOUT`.
- **FECHAR**
  - `Barreira2 = 1`.
  - `conta_ciclos` holds its last value.
  - This is a one-cycle guard state; the next state is always FECHADA.
- `MatrVal` in ABERTA or FECHAR:
  - the plate is ignored and `MatrErro` pulses;
  - `Matr_atual` is unchanged;
  - the counter is not restarted.
  - This also applies to a repeat of the same plate.
- In FECHADA, `conta_ciclos` holds the value from the last event until the next acceptance clears it.
- `ciclos_aberto` is sampled live every cycle, not latched.
- **Arithmetic:**
  - `ciclos_aberto` and `conta_ciclos` are compared as unsigned CNT_W-bit values.
  - The counter never wraps.

## Timing
- **Reset values:**
  - state FECHADA;
  - `Barreira2 = 1`;
  - `conta_ciclos = 0`;
  - `MatrAceite = 0`;
  - `MatrErro = 0`;
  - `Matr_atual = 0`;
  - `passou = 0`.
- Reset asserted mid-event closes the barrier on the next edge, with all values as listed above.
- **Latency:** with `MatrVal` sampled at edge n:
  - `MatrAceite = 1` and `Barreira2 = 0` after edge n;
  - `conta_ciclos = 0` after edge n, reaching 1 after edge n+1.
- All outputs are registered. There is no combinational path from input to output.
- `MatrAceite` and `MatrErro` are high for exactly one cycle, and never both in the same cycle.
- Sensor and count condition met simultaneously: the close decision is taken on that edge, and `Barreira2 = 1` after the following edge.
- A sensor pulse before the minimum open time is remembered. The barrier closes as soon as `conta_ciclos` reaches `ciclos_aberto`.
- `sensor_passagem` in FECHADA or FECHAR is ignored.

## Structure
- Shared package `parque_pkg`:
  - state encoding (FECHADA = 2'd0, ABERTA = 2'd1, FECHAR = 2'd2);
  - `MATR_INVALIDA = 24'h000000`;
  - default `CNT_W` and `TIMEOUT`.
- Sub-module `contador_ciclos`: saturating counter with `clr`/`en` inputs, CNT_W bits wide, saturating at `TIMEOUT`. It is reused by the closing side.
- Top level contains the FSM, the plate latch, the `passou` flag and the pulse registers.

## Test plan
- **Reset:** hold `reset` 3 cycles → `Barreira2 = 1`, `conta_ciclos = 0`, `Matr_atual = 0`, no pulses.
- **Normal pass:**
  - stimulus: `ciclos_aberto = 10`, `Matricula = 24'h4A21BC` with `MatrVal`, `sensor_passagem` pulsed at count 15;
  - response: `MatrAceite` one cycle, `Barreira2 = 0`, FECHAR decided at count 15, `Barreira2 = 1` two edges after the sensor sample, `conta_ciclos` held at 16.
- **Early sensor:**
  - stimulus: `ciclos_aberto = 20`, sensor pulsed at count 3;
  - response: barrier stays open and closes when `conta_ciclos` reaches 20.
- **Timeout:**
  - stimulus: no sensor;
  - response: `conta_ciclos` saturates at 127, then `Barreira2 = 1`.
- **Rejections:**
  - `Matricula = 0` in FECHADA → `MatrErro` pulse and no opening;
  - second plate 24'h111111 during ABERTA → `MatrErro` pulse, `Matr_atual` unchanged, count continues.
- **Reset mid-event:**
  - stimulus: `reset` asserted at count 5;
  - response: `Barreira2 = 1` and `conta_ciclos = 0` next cycle;
  - a new `MatrVal` after reset release opens the barrier normally.
